spart_driver: RTL and testbench
===============================

# spart_driver

Bus-master sequencer for the SPART register interface. It programs the 16-bit baud divisor from a 2-bit rate select, then services the SPART forever: it reads received bytes out and hands them to the user side, and it feeds queued user bytes into the transmit buffer one at a time. It sits between the SPART (`iocs`/`iorw`/`ioaddr`/`databus`/`rda`/`tbr`) and the surrounding processor-side logic, and it is the only master on `databus`.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency, used for the divisor constants.
- `TXQ_DEPTH`, default 4: transmit queue depth; must be a power of 2.

Ports:
- `clk` input 1: system clock. One clock; all state is on its rising edge.
- `rst` input 1: reset. Asynchronous and active-low (despite the name).
- `br_cfg` input 2: rate select. 00=4800, 01=9600, 10=19200, 11=38400 baud.
- `tx_valid` input 1: user byte offered.
- `tx_data` input 8: user byte.
- `tx_ready` output 1: queue not full. A byte is accepted when `tx_valid && tx_ready`.
- `rx_valid` output 1: one-cycle pulse; a received byte is on `rx_data`.
- `rx_data` output 8: last received byte. Held between pulses.
- `iocs` output 1: SPART chip select.
- `iorw` output 1: 1 = read from SPART, 0 = write to SPART.
- `ioaddr` output 2: 00 = TX/RX buffer, 01 = status, 10 = DB low, 11 = DB high.
- `databus` inout 8: driven only when `iorw==0`, otherwise high-Z.
- `rda` input 1: SPART receive data available.
- `tbr` input 1: SPART transmit buffer ready.

## Operation

- Divisor is `CLK_HZ/baud - 1`, using floor division. At 50 MHz: 4800→0x28AF, 9600→0x1457, 19200→0x0A2B, 38400→0x0515.
- Idle bus state: `iocs=0`, `iorw=1`, `ioaddr=01`. Addresses 10 and 11 are never presented with `iorw=0` outside the CFG states, because the SPART latches DB writes without `iocs`.
- FSM states and actions:
  - CFG_LO: write DB low byte to addr 10.
  - CFG_HI: write DB high byte to addr 11; latch `br_cfg` into `br_q`.
  - IDLE: bus parked in the idle state.
  - RX_RD: `iocs=1`, `iorw=1`, `ioaddr=00`; capture `databus` at the end of the cycle.
  - TX_WR: `iocs=1`, `iorw=0`, `ioaddr=00`; drive the queue head and pop it.
- IDLE priority, highest first:
  1. `br_cfg != br_q` and `!tx_inflight` → CFG_LO.
  2. `rda` and `!rx_hold` → RX_RD.
  3. Queue non-empty and `!tx_inflight` → TX_WR.
- Every non-IDLE state lasts exactly 1 cycle and returns to IDLE. CFG_LO always goes to CFG_HI.
- `tx_inflight` is set in TX_WR. It clears on a rising edge of `tbr` (registered `tbr_q==0 && tbr==1`). The reset value of 0 allows the first transmit without ever seeing `tbr`.
- `rx_hold` is set for the 1 cycle after RX_RD, so the SPART's registered `rda` clear is not double-read.
- SPART contract: a read of addr 00 clears `rda`.
- Queue:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - A push when full is ignored (`tx_ready=0`).
  - Pointers wrap modulo `TXQ_DEPTH`; occupancy counter is log2(`TXQ_DEPTH`)+1 bits.
- Changing `br_cfg` during a transmit defers reconfiguration until `tx_inflight` clears. A receive in progress is not protected.

## Timing

- Reset values:
  - Outputs: `iocs=0`, `iorw=1`, `ioaddr=01`, `databus` high-Z, `rx_valid=0`, `rx_data=0x00`, `tx_ready=1`.
  - Internal: queue empty, `tx_inflight=0`, `rx_hold=0`, `br_q=00`, state CFG_LO.
- After reset release:
  - cycle 0: CFG_LO
  - cycle 1: CFG_HI
  - cycle 2: IDLE
- Receive: `rda` seen in IDLE at cycle n → RX_RD at n+1 → `rx_valid=1` with data at n+2.
- Transmit latency: push at cycle n into an empty queue with bus idle → TX_WR at n+2 (n+1 = queue registered; n+2 = IDLE decision drives TX_WR).
- Reset asserted mid-operation: all state returns to reset values immediately. Queue contents are discarded, and the divisor is reprogrammed on release.

## Structure

- Package `spart_pkg`:
  - Address constants: `ADDR_BUF`, `ADDR_STAT`, `ADDR_DBL`, `ADDR_DBH`.
  - FSM state enum.
  - Divisor function of (`CLK_HZ`, `br_cfg`).
- Sub-module `spart_txq`: synchronous FIFO with `push`/`pop`/`full`/`empty`/`head`, parameterised by depth. The FSM stays in `spart_driver`.

## Test plan

- Reset, then `br_cfg=01` → addr 10 written with 0x57, then addr 11 written with 0x14, on the first two cycles; then bus idle (`iocs=0`, `iorw=1`, `ioaddr=01`).
- SPART model raises `rda` with 0xA5 on the bus → one RX_RD cycle → `rx_valid` for 1 cycle with `rx_data=0xA5`; exactly one read per `rda` assertion.
- Push 0x11, 0x22, 0x33, 0x44 back-to-back → `tx_ready` drops after the 4th. Writes appear in order, each only after a `tbr` rising edge that follows the previous write.
- `rda` and a non-empty queue in the same IDLE cycle → RX_RD first, TX_WR on the next IDLE decision.
- `br_cfg` changed 00→11 while `tx_inflight` → no DB write until `tbr` rises, then 0x15 to addr 10 and 0x05 to addr 11.
- `rst` pulsed low while the queue holds 3 bytes → queue empty, `tx_ready=1`, CFG sequence repeats, and no stale bytes are transmitted.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master sequencer: register
// addresses, sequencer states and the baud divisor calculation.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    TX_WR
  } state_t;

  // Rate select picks 4800 << sel baud; divisor is floor(clk/baud) - 1.
  function automatic logic [15:0] divisor(input int unsigned clk_hz,
                                          input logic [1:0]    sel);
    int unsigned baud;
    baud = 32'd4800 << sel;
    return 16'(clk_hz / baud - 32'd1);
  endfunction

endpackage

// File: rtl/spart_txq.sv
// Small synchronous FIFO holding user bytes waiting for the SPART
// transmit buffer. Push when full and pop when empty are ignored;
// a simultaneous push and pop leaves occupancy unchanged.
module spart_txq #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spart_driver.sv
// Bus-master sequencer for the SPART: programs the baud divisor, then
// drains received bytes to the user side and feeds queued user bytes
// into the transmit buffer one at a time.
//
// User transmit handshake: a byte is taken on any rising clock edge where
// tx_valid && tx_ready; tx_ready is simply "queue not full" and never
// depends on tx_valid. rx_valid is a one-cycle pulse with no back-pressure.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int          TXQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr
);

  state_t      state;
  state_t      next_state;
  logic [1:0]  br_q;
  logic        tx_inflight;
  logic        rx_hold;
  logic        tbr_q;
  logic        q_full;
  logic        q_empty;
  logic        q_pop;
  logic [7:0]  q_head;
  logic [15:0] div;
  logic        bus_cs;
  logic        bus_rw;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_dout;

  assign div      = divisor(CLK_HZ, br_cfg);
  assign tx_ready = !q_full;

  spart_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk   (clk),
    .rst_n (rst),
    .push  (tx_valid),
    .pop   (q_pop),
    .din   (tx_data),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Sequencer state register; reset lands in CFG_LO so the divisor is
  // rewritten every time reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CFG_LO;
    else      state <= next_state;
  end

  // Next-state choice and per-state bus cycle; IDLE parks the bus on the
  // harmless status address with the SPART deselected.
  always_comb begin
    next_state = state;
    bus_cs     = 1'b0;
    bus_rw     = 1'b1;
    bus_addr   = ADDR_STAT;
    bus_dout   = 8'h00;
    q_pop      = 1'b0;
    case (state)
      CFG_LO: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = ADDR_DBL;
        bus_dout   = div[7:0];
        next_state = CFG_HI;
      end
      CFG_HI: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = ADDR_DBH;
        bus_dout   = div[15:8];
        next_state = IDLE;
      end
      IDLE: begin
        if ((br_cfg != br_q) && !tx_inflight) next_state = CFG_LO;
        else if (rda && !rx_hold)             next_state = RX_RD;
        else if (!q_empty && !tx_inflight)    next_state = TX_WR;
      end
      RX_RD: begin
        bus_cs     = 1'b1;
        bus_addr   = ADDR_BUF;
        next_state = IDLE;
      end
      TX_WR: begin
        bus_cs     = 1'b1;
        bus_rw     = 1'b0;
        bus_addr   = ADDR_BUF;
        bus_dout   = q_head;
        q_pop      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // While reset is held the bus is forced to its parked state even
  // though the state register sits in CFG_LO.
  assign iocs    = rst & bus_cs;
  assign iorw    = ~rst | bus_rw;
  assign ioaddr  = rst ? bus_addr : ADDR_STAT;
  assign databus = (rst && !bus_rw) ? bus_dout : 8'hzz;

  // Link bookkeeping: a write marks the transmitter busy until tbr rises;
  // the cycle after a read is masked so a late rda clear is not re-read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_inflight <= 1'b0;
      rx_hold     <= 1'b0;
      tbr_q       <= 1'b0;
      br_q        <= 2'b00;
    end else begin
      tbr_q   <= tbr;
      rx_hold <= (state == RX_RD);
      if (state == TX_WR)     tx_inflight <= 1'b1;
      else if (!tbr_q && tbr) tx_inflight <= 1'b0;
      if (state == CFG_HI)    br_q <= br_cfg;
    end
  end

  // Receive capture: the byte is sampled at the end of the read cycle and
  // presented with a one-cycle valid pulse; the data is held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      rx_valid <= (state == RX_RD);
      if (state == RX_RD) rx_data <= databus;
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver with a behavioural SPART model.
module tb_spart_driver;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [1:0] br_cfg   = 2'b00;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda      = 1'b0;
  logic       tbr      = 1'b1;

  // SPART model state and stimulus controls
  logic [7:0] rx_byte  = 8'h00;
  logic [7:0] rda_byte = 8'h00;
  logic       rda_set  = 1'b0;
  int         tbr_delay = 10;
  int         tbr_cnt   = 0;

  // Monitor counters and logs
  int         rd_cnt    = 0;
  int         early_cnt = 0;
  int         cfg_busy  = 0;
  logic [9:0] wr_log[$];
  logic [7:0] rxv_log[$];

  // Scoreboard
  logic [9:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;
  cfg_vec_t vecs[4];

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr)
  );

  // Clock
  always #5 clk = ~clk;

  // SPART model: drives the RX byte on buffer reads, clears rda on a read,
  // drops tbr on a buffer write and raises it tbr_delay cycles later.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? rx_byte : 8'hzz;

  always @(posedge clk) begin
    if (iocs && !iorw && ioaddr == 2'b00) begin
      tbr     <= 1'b0;
      tbr_cnt <= tbr_delay;
    end else if (!tbr) begin
      if (tbr_cnt == 0) tbr <= 1'b1;
      else              tbr_cnt <= tbr_cnt - 1;
    end
    if (iocs && iorw && ioaddr == 2'b00) begin
      rda <= 1'b0;
    end else if (rda_set) begin
      rda     <= 1'b1;
      rx_byte <= rda_byte;
    end
  end

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (iocs && !iorw) begin
        wr_log.push_back({ioaddr, databus});
        if (ioaddr == 2'b00 && !tbr) early_cnt <= early_cnt + 1;
        if (ioaddr[1] && !tbr)       cfg_busy  <= cfg_busy + 1;
      end
      if (iocs && iorw && ioaddr == 2'b00) rd_cnt <= rd_cnt + 1;
      if (rx_valid) rxv_log.push_back(rx_data);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus triple {iocs, iorw, ioaddr}
  task automatic chk_bus(input string name, input logic [3:0] exp);
    chk(name, 16'({iocs, iorw, ioaddr}), 16'(exp));
  endtask

  task automatic check_writes(input string name, input int base);
    chk($sformatf("%s_count", name), 16'(wr_log.size() - base), 16'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < wr_log.size())
        chk($sformatf("%s_wr%0d", name, k), 16'(wr_log[base + k]), 16'(exp_q[k]));
    end
    exp_q.delete();
  endtask

  initial begin
    int base;
    int cnt_base;
    int rxv_base;

    vecs[0] = '{2'b01, 8'h57, 8'h14};
    vecs[1] = '{2'b10, 8'h2B, 8'h0A};
    vecs[2] = '{2'b11, 8'h15, 8'h05};
    vecs[3] = '{2'b00, 8'hAF, 8'h28};

    // Reset values and the divisor write for each rate select
    for (int i = 0; i < 4; i++) begin
      tick();
      rst    = 1'b0;
      br_cfg = vecs[i].sel;
      @(negedge clk);
      chk_bus($sformatf("rst_bus%0d", i), 4'b0101);
      chk($sformatf("rst_rxv%0d", i), 16'(rx_valid), 16'd0);
      chk($sformatf("rst_rxd%0d", i), 16'(rx_data), 16'h00);
      chk($sformatf("rst_txr%0d", i), 16'(tx_ready), 16'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk_bus($sformatf("cfg_lo_bus%0d", i), 4'b1010);
      chk($sformatf("cfg_lo_data%0d", i), 16'(databus), 16'(vecs[i].lo));
      @(negedge clk);
      chk_bus($sformatf("cfg_hi_bus%0d", i), 4'b1011);
      chk($sformatf("cfg_hi_data%0d", i), 16'(databus), 16'(vecs[i].hi));
      @(negedge clk);
      chk_bus($sformatf("idle_bus%0d", i), 4'b0101);
    end

    // Single receive: rda seen in IDLE at n, read at n+1, pulse at n+2
    tick();
    cnt_base = rd_cnt;
    rxv_base = rxv_log.size();
    rda_byte = 8'hA5;
    rda_set  = 1'b1;
    tick();
    rda_set = 1'b0;
    @(negedge clk);
    chk_bus("rx_n_idle", 4'b0101);
    @(negedge clk);
    chk_bus("rx_rd_bus", 4'b1100);
    @(negedge clk);
    chk("rx_valid_hi", 16'(rx_valid), 16'd1);
    chk("rx_data", 16'(rx_data), 16'hA5);
    @(negedge clk);
    chk("rx_valid_lo", 16'(rx_valid), 16'd0);
    repeat (5) tick();
    chk("rx_reads", 16'(rd_cnt - cnt_base), 16'd1);
    chk("rx_pulses", 16'(rxv_log.size() - rxv_base), 16'd1);
    chk("rx_held", 16'(rx_data), 16'hA5);

    // Transmit ordering and queue full: first byte goes out and stays in
    // flight while four more fill the queue
    tbr_delay = 10;
    base      = wr_log.size();
    cnt_base  = early_cnt;
    tx_valid  = 1'b1;
    tx_data   = 8'h10;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 1; k <= 4; k++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(k * 8'h11);
      tick();
    end
    tx_valid = 1'b0;
    chk("tx_full_ready", 16'(tx_ready), 16'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    tick();
    tx_valid = 1'b0;
    chk("tx_still_full", 16'(tx_ready), 16'd0);
    exp_q.push_back({2'b00, 8'h10});
    exp_q.push_back({2'b00, 8'h11});
    exp_q.push_back({2'b00, 8'h22});
    exp_q.push_back({2'b00, 8'h33});
    exp_q.push_back({2'b00, 8'h44});
    repeat (90) tick();
    check_writes("tx_order", base);
    chk("tx_early", 16'(early_cnt - cnt_base), 16'd0);
    chk("tx_drained_ready", 16'(tx_ready), 16'd1);

    // Receive wins over transmit in the same IDLE decision
    tx_valid = 1'b1;
    tx_data  = 8'h66;
    rda_byte = 8'h3C;
    rda_set  = 1'b1;
    tick();
    tx_valid = 1'b0;
    rda_set  = 1'b0;
    @(negedge clk);
    chk_bus("prio_idle", 4'b0101);
    @(negedge clk);
    chk_bus("prio_rx_first", 4'b1100);
    @(negedge clk);
    chk_bus("prio_idle2", 4'b0101);
    chk("prio_rx_data", 16'(rx_data), 16'h3C);
    @(negedge clk);
    chk_bus("prio_tx_next", 4'b1000);
    chk("prio_tx_data", 16'(databus), 16'h66);

    // Rate change while the 0x66 write is in flight is deferred
    tick();
    base     = wr_log.size();
    cnt_base = cfg_busy;
    br_cfg   = 2'b11;
    exp_q.push_back({2'b10, 8'h15});
    exp_q.push_back({2'b11, 8'h05});
    repeat (30) tick();
    check_writes("cfg_defer", base);
    chk("cfg_defer_busy", 16'(cfg_busy - cnt_base), 16'd0);

    // Reset with three bytes queued behind an in-flight write
    tbr_delay = 15;
    tx_valid  = 1'b1;
    tx_data   = 8'h81;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int k = 2; k <= 4; k++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(8'h80 + k);
      tick();
    end
    tx_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 16'(tx_ready), 16'd1);
    chk_bus("rst_mid_bus", 4'b0101);
    tick();
    base = wr_log.size();
    rst  = 1'b1;
    @(negedge clk);
    chk_bus("rst_mid_cfg_lo", 4'b1010);
    chk("rst_mid_lo", 16'(databus), 16'h15);
    @(negedge clk);
    chk_bus("rst_mid_cfg_hi", 4'b1011);
    chk("rst_mid_hi", 16'(databus), 16'h05);
    exp_q.push_back({2'b10, 8'h15});
    exp_q.push_back({2'b11, 8'h05});
    repeat (40) tick();
    check_writes("rst_mid", base);
    chk("rst_mid_ready_end", 16'(tx_ready), 16'd1);
    chk("total_reads", 16'(rd_cnt), 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
